// File: rtl/am2901_pkg.sv
// am2901_pkg: microinstruction field encodings and multiply sequencer states
package am2901_pkg;
  typedef enum logic [2:0] {SRC_AQ, SRC_AB, SRC_ZQ, SRC_ZB, SRC_ZA, SRC_DA, SRC_DQ, SRC_DZ} src_e;
  typedef enum logic [2:0] {FN_ADD, FN_SUBR, FN_SUBS, FN_OR, FN_AND, FN_NOTRS, FN_EXOR, FN_EXNOR} fn_e;
  typedef enum logic [2:0] {DST_QREG, DST_NOP, DST_RAMA, DST_RAMF, DST_RAMQD, DST_RAMD, DST_RAMQU, DST_RAMU} dst_e;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_WB} state_e;
  localparam int SRC_LSB = 0;
  localparam int FN_LSB = 3;
  localparam int DST_LSB = 6;
endpackage

// File: rtl/am2901_alu.sv
// am2901_alu: combinational WIDTH-bit ALU with carry, overflow and lookahead terms
module am2901_alu
  import am2901_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_s,
  input  logic             i_cin,
  input  fn_e              i_fn,
  output logic [WIDTH-1:0] o_f,
  output logic             o_cout,
  output logic             o_ovr,
  output logic             o_g_lo,
  output logic             o_p_lo
);
  logic [WIDTH-1:0] w_r, w_s, w_p, w_g, w_low;
  logic [WIDTH:0]   w_sum;
  logic             w_arith, w_gg;
  assign w_arith = i_fn inside {FN_ADD, FN_SUBR, FN_SUBS};
  assign w_r     = (i_fn == FN_SUBR) ? ~i_r : i_r;
  assign w_s     = (i_fn == FN_SUBS) ? ~i_s : i_s;
  assign w_sum   = {1'b0, w_r} + {1'b0, w_s} + {{WIDTH{1'b0}}, i_cin};
  // carry into the MSB comes from adding only the low WIDTH-1 bits
  assign w_low   = {1'b0, w_r[WIDTH-2:0]} + {1'b0, w_s[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, i_cin};
  assign w_p     = w_r | w_s;
  assign w_g     = w_r & w_s;
  always_comb begin
    w_gg = w_g[0];
    for (int k = 1; k < WIDTH; k++) w_gg = w_g[k] | (w_p[k] & w_gg);
  end
  always_comb begin
    case (i_fn)
      FN_ADD, FN_SUBR, FN_SUBS: o_f = w_sum[WIDTH-1:0];
      FN_OR:    o_f = i_r | i_s;
      FN_AND:   o_f = i_r & i_s;
      FN_NOTRS: o_f = ~i_r & i_s;
      FN_EXOR:  o_f = i_r ^ i_s;
      default:  o_f = ~(i_r ^ i_s);
    endcase
  end
  assign o_cout = w_arith & w_sum[WIDTH];
  assign o_ovr  = w_arith & (w_sum[WIDTH] ^ w_low[WIDTH-1]);
  assign o_p_lo = ~&w_p;
  assign o_g_lo = ~w_gg;
endmodule

// File: rtl/am2901_wide.sv
// am2901_wide: parametrised Am2901-style bit-slice datapath with a shift-and-add multiply sequencer
module am2901_wide
  import am2901_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int REGS  = 16,
  localparam int AW    = $clog2(REGS)
) (
  input  logic             cp,
  input  logic             rst,
  input  logic [8:0]       i,
  input  logic [AW-1:0]    a,
  input  logic [AW-1:0]    b,
  input  logic [WIDTH-1:0] d,
  input  logic             cin,
  input  logic             oe_n,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovr,
  output logic             z,
  output logic             f_msb,
  output logic             g_lo,
  output logic             p_lo,
  input  logic             ram_lsb_in,
  input  logic             ram_msb_in,
  input  logic             q_lsb_in,
  input  logic             q_msb_in,
  output logic             ram_lsb_out,
  output logic             ram_msb_out,
  output logic             q_lsb_out,
  output logic             q_msb_out,
  output logic             ram_lsb_oe,
  output logic             ram_msb_oe,
  output logic             q_lsb_oe,
  output logic             q_msb_oe,
  input  logic             mul_start,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] r_ram [REGS];
  logic [WIDTH-1:0] r_q, r_acc, r_m;
  logic [AW-1:0]    r_bl;
  logic [CW-1:0]    r_cnt;
  state_e           r_state;
  src_e             w_src;
  fn_e              w_fn;
  dst_e             w_dst;
  logic [WIDTH-1:0] w_ra, w_rb, w_r, w_s, w_f, w_ram_d, w_q_d;
  logic [WIDTH:0]   w_mac;
  logic             w_down, w_up, w_ram_we, w_q_we;
  assign w_src = src_e'(i[SRC_LSB +: 3]);
  assign w_fn  = fn_e'(i[FN_LSB +: 3]);
  assign w_dst = dst_e'(i[DST_LSB +: 3]);
  assign w_ra  = r_ram[a];
  assign w_rb  = r_ram[b];
  assign w_r = (w_src inside {SRC_AQ, SRC_AB}) ? w_ra :
               (w_src inside {SRC_DA, SRC_DQ, SRC_DZ}) ? d : '0;
  assign w_s = (w_src inside {SRC_AQ, SRC_ZQ, SRC_DQ}) ? r_q :
               (w_src inside {SRC_AB, SRC_ZB}) ? w_rb :
               (w_src inside {SRC_ZA, SRC_DA}) ? w_ra : '0;
  am2901_alu #(.WIDTH(WIDTH)) u_alu (
    .i_r(w_r), .i_s(w_s), .i_cin(cin), .i_fn(w_fn),
    .o_f(w_f), .o_cout(cout), .o_ovr(ovr), .o_g_lo(g_lo), .o_p_lo(p_lo)
  );
  assign busy  = r_state != ST_IDLE;
  assign done  = r_state == ST_WB;
  assign y     = oe_n ? '0 : busy ? r_acc : (w_dst == DST_RAMA) ? w_ra : w_f;
  assign z     = ~|w_f;
  assign f_msb = w_f[WIDTH-1];
  assign w_down      = w_dst inside {DST_RAMQD, DST_RAMD};
  assign w_up        = w_dst inside {DST_RAMQU, DST_RAMU};
  assign ram_lsb_oe  = w_down;
  assign q_lsb_oe    = w_down;
  assign ram_msb_oe  = w_up;
  assign q_msb_oe    = w_up;
  assign ram_lsb_out = w_down & w_f[0];
  assign q_lsb_out   = w_down & r_q[0];
  assign ram_msb_out = w_up & w_f[WIDTH-1];
  assign q_msb_out   = w_up & r_q[WIDTH-1];
  assign w_ram_we = !(w_dst inside {DST_QREG, DST_NOP});
  assign w_ram_d  = w_down ? {ram_msb_in, w_f[WIDTH-1:1]} : w_up ? {w_f[WIDTH-2:0], ram_lsb_in} : w_f;
  assign w_q_we   = w_dst inside {DST_QREG, DST_RAMQD, DST_RAMQU};
  assign w_q_d    = (w_dst == DST_RAMQD) ? {q_msb_in, r_q[WIDTH-1:1]} :
                    (w_dst == DST_RAMQU) ? {r_q[WIDTH-2:0], q_lsb_in} : w_f;
  // multiplier LSB lives in Q[0]; product bits shift into Q from the top
  assign w_mac = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < REGS; k++) r_ram[k] <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_m     <= '0;
      r_bl    <= '0;
      r_cnt   <= '0;
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:
          if (mul_start) begin
            r_m     <= w_rb;
            r_bl    <= b;
            r_q     <= w_ra;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_MUL;
          end else begin
            if (w_ram_we) r_ram[b] <= w_ram_d;
            if (w_q_we) r_q <= w_q_d;
          end
        ST_MUL: begin
          r_acc <= w_mac[WIDTH:1];
          r_q   <= {w_mac[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= ST_WB;
        end
        ST_WB: begin
          r_ram[r_bl] <= r_acc;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_am2901_wide.sv
// tb_am2901_wide: randomized and directed checks of am2901_wide against a behavioural model
module tb_am2901_wide;
  logic       cp = 1'b0, rst = 1'b1;
  logic [8:0] i;
  logic [3:0] a, b;
  logic [7:0] d, y;
  logic       cin, oe_n, cout, ovr, z, f_msb, g_lo, p_lo;
  logic       ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in;
  logic       ram_lsb_out, ram_msb_out, q_lsb_out, q_msb_out;
  logic       ram_lsb_oe, ram_msb_oe, q_lsb_oe, q_msb_oe;
  logic       mul_start, busy, done;
  int         checks = 0, errors = 0;
  logic [7:0] mr [16];
  logic [7:0] mq;

  am2901_wide #(.WIDTH(8), .REGS(16)) dut (
    .cp(cp), .rst(rst), .i(i), .a(a), .b(b), .d(d), .cin(cin), .oe_n(oe_n), .y(y),
    .cout(cout), .ovr(ovr), .z(z), .f_msb(f_msb), .g_lo(g_lo), .p_lo(p_lo),
    .ram_lsb_in(ram_lsb_in), .ram_msb_in(ram_msb_in), .q_lsb_in(q_lsb_in), .q_msb_in(q_msb_in),
    .ram_lsb_out(ram_lsb_out), .ram_msb_out(ram_msb_out), .q_lsb_out(q_lsb_out), .q_msb_out(q_msb_out),
    .ram_lsb_oe(ram_lsb_oe), .ram_msb_oe(ram_msb_oe), .q_lsb_oe(q_lsb_oe), .q_msb_oe(q_msb_oe),
    .mul_start(mul_start), .busy(busy), .done(done)
  );

  always #5 cp = ~cp;

  function automatic logic [8:0] ins(input logic [2:0] dst, input logic [2:0] fn, input logic [2:0] src);
    return {dst, fn, src};
  endfunction

  task automatic setin(input logic [8:0] ii, input logic [3:0] aa, input logic [3:0] bb,
                       input logic [7:0] dd, input logic cc);
    i = ii; a = aa; b = bb; d = dd; cin = cc;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 16; k++) mr[k] = 8'h00;
    mq = 8'h00;
  endtask

  // arithmetic done on plain integers; overflow from the signed sum range
  task automatic model(output logic [7:0] f, output logic [7:0] ey, output logic [5:0] fl, output logic [7:0] sh);
    logic [7:0] rv, sv, rr, ss;
    byte        sr, sb;
    int         us, ssum;
    logic       ar, dn, up;
    case (i[2:0])
      3'd0: begin rv = mr[a]; sv = mq;    end
      3'd1: begin rv = mr[a]; sv = mr[b]; end
      3'd2: begin rv = 0;     sv = mq;    end
      3'd3: begin rv = 0;     sv = mr[b]; end
      3'd4: begin rv = 0;     sv = mr[a]; end
      3'd5: begin rv = d;     sv = mr[a]; end
      3'd6: begin rv = d;     sv = mq;    end
      default: begin rv = d;  sv = 0;     end
    endcase
    rr = (i[5:3] == 3'd1) ? ~rv : rv;
    ss = (i[5:3] == 3'd2) ? ~sv : sv;
    us = int'(rr) + int'(ss) + int'(cin);
    sr = rr; sb = ss;
    ssum = int'(sr) + int'(sb) + int'(cin);
    ar = i[5:3] <= 3'd2;
    case (i[5:3])
      3'd3: f = rv | sv;
      3'd4: f = rv & sv;
      3'd5: f = ~rv & sv;
      3'd6: f = rv ^ sv;
      3'd7: f = ~(rv ^ sv);
      default: f = us[7:0];
    endcase
    ey = oe_n ? 8'h00 : (i[8:6] == 3'd2) ? mr[a] : f;
    fl = {ar && us > 255, ar && (ssum > 127 || ssum < -128), f == 8'h00, f[7],
          !(int'(rr) + int'(ss) > 255), (rr | ss) != 8'hFF};
    dn = i[8:6] == 3'd4 || i[8:6] == 3'd5;
    up = i[8:6] == 3'd6 || i[8:6] == 3'd7;
    sh = {dn & f[0], up & f[7], dn & mq[0], up & mq[7], dn, up, dn, up};
  endtask

  task automatic commit();
    logic [7:0] f, ey, sh;
    logic [5:0] fl;
    model(f, ey, fl, sh);
    case (i[8:6])
      3'd0: mq = f;
      3'd2, 3'd3: mr[b] = f;
      3'd4: begin mr[b] = (f >> 1) | (8'(ram_msb_in) << 7); mq = (mq >> 1) | (8'(q_msb_in) << 7); end
      3'd5: mr[b] = (f >> 1) | (8'(ram_msb_in) << 7);
      3'd6: begin mr[b] = (f << 1) | 8'(ram_lsb_in); mq = (mq << 1) | 8'(q_lsb_in); end
      3'd7: mr[b] = (f << 1) | 8'(ram_lsb_in);
      default: ;
    endcase
  endtask

  task automatic tick(input bit upd);
    if (upd) commit();
    @(posedge cp);
    #1;
  endtask

  task automatic test_reset();
    setin(ins(3'd1, 3'd3, 3'd4), 0, 0, 8'h00, 1'b0);
    #3;
    checks++;
    if ({y, busy, done} !== 10'h000) begin
      errors++; $display("FAIL reset_hold y=%h busy=%b done=%b expected 00 0 0", y, busy, done);
    end
    @(negedge cp) rst = 1'b0;
    tick(0);
    checks++;
    if ({y, busy, done} !== 10'h000) begin
      errors++; $display("FAIL reset_release y=%h busy=%b done=%b expected 00 0 0", y, busy, done);
    end
  endtask

  task automatic test_overflow();
    setin(ins(3'd3, 3'd3, 3'd7), 0, 1, 8'h7F, 1'b0); tick(1);
    setin(ins(3'd3, 3'd3, 3'd7), 0, 2, 8'h01, 1'b0); tick(1);
    setin(ins(3'd3, 3'd0, 3'd1), 1, 2, 8'h00, 1'b0); #1;
    checks++;
    if ({y, ovr, cout, f_msb, z} !== {8'h80, 4'b1010}) begin
      errors++; $display("FAIL overflow y=%h ovr=%b cout=%b fmsb=%b z=%b expected 80 1 0 1 0", y, ovr, cout, f_msb, z);
    end
    tick(1);
    setin(ins(3'd1, 3'd3, 3'd4), 2, 0, 8'h00, 1'b0); #1;
    checks++;
    if (y !== 8'h80) begin errors++; $display("FAIL overflow_wb R2=%h expected 80", y); end
  endtask

  task automatic test_shift_down();
    setin(ins(3'd3, 3'd3, 3'd7), 0, 3, 8'h81, 1'b0); tick(1);
    setin(ins(3'd0, 3'd3, 3'd7), 0, 0, 8'h01, 1'b0); tick(1);
    ram_msb_in = 1'b1; q_msb_in = 1'b0;
    setin(ins(3'd4, 3'd3, 3'd3), 0, 3, 8'h00, 1'b0); #1;
    checks++;
    if ({ram_lsb_out, q_lsb_out, ram_lsb_oe, q_lsb_oe, ram_msb_oe, q_msb_oe, ram_msb_out, q_msb_out} !== 8'b11110000) begin
      errors++; $display("FAIL shift_down_outs got %b%b%b%b%b%b%b%b expected 11110000", ram_lsb_out, q_lsb_out,
                         ram_lsb_oe, q_lsb_oe, ram_msb_oe, q_msb_oe, ram_msb_out, q_msb_out);
    end
    tick(1);
    setin(ins(3'd1, 3'd3, 3'd4), 3, 0, 8'h00, 1'b0); #1;
    checks++;
    if (y !== 8'hC0) begin errors++; $display("FAIL shift_down_ram R3=%h expected c0", y); end
    setin(ins(3'd1, 3'd3, 3'd2), 0, 0, 8'h00, 1'b0); #1;
    checks++;
    if (y !== 8'h00) begin errors++; $display("FAIL shift_down_q Q=%h expected 00", y); end
    ram_msb_in = 1'b0;
  endtask

  task automatic test_carry_zero();
    setin(ins(3'd3, 3'd3, 3'd7), 0, 4, 8'hFF, 1'b0); tick(1);
    setin(ins(3'd3, 3'd3, 3'd7), 0, 5, 8'h01, 1'b0); tick(1);
    setin(ins(3'd1, 3'd0, 3'd1), 4, 5, 8'h00, 1'b0); #1;
    checks++;
    if ({y, z, cout, p_lo, g_lo} !== {8'h00, 4'b1100}) begin
      errors++; $display("FAIL carry_zero y=%h z=%b cout=%b p_lo=%b g_lo=%b expected 00 1 1 0 0", y, z, cout, p_lo, g_lo);
    end
    tick(1);
  endtask

  task automatic test_random();
    logic [7:0] f, ey, sh;
    logic [5:0] fl;
    for (int n = 0; n < 200; n++) begin
      setin(9'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
      {ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in} = 4'($urandom);
      oe_n = ($urandom_range(7) == 0);
      #1;
      model(f, ey, fl, sh);
      checks++;
      if (y !== ey) begin errors++; $display("FAIL rand_y n=%0d i=%o y=%h expected %h", n, i, y, ey); end
      checks++;
      if ({cout, ovr, z, f_msb, g_lo, p_lo} !== fl) begin
        errors++; $display("FAIL rand_flags n=%0d i=%o got %b expected %b", n, i, {cout, ovr, z, f_msb, g_lo, p_lo}, fl);
      end
      checks++;
      if ({ram_lsb_out, ram_msb_out, q_lsb_out, q_msb_out, ram_lsb_oe, ram_msb_oe, q_lsb_oe, q_msb_oe} !== sh) begin
        errors++; $display("FAIL rand_shift n=%0d i=%o got %b expected %b", n, i,
                           {ram_lsb_out, ram_msb_out, q_lsb_out, q_msb_out, ram_lsb_oe, ram_msb_oe, q_lsb_oe, q_msb_oe}, sh);
      end
      tick(1);
    end
    oe_n = 1'b0;
    for (int k = 0; k < 16; k++) begin
      setin(ins(3'd1, 3'd3, 3'd4), 4'(k), 0, 8'h00, 1'b0); #1;
      checks++;
      if (y !== mr[k]) begin errors++; $display("FAIL rand_reg R%0d=%h expected %h", k, y, mr[k]); end
    end
    setin(ins(3'd1, 3'd3, 3'd2), 0, 0, 8'h00, 1'b0); #1;
    checks++;
    if (y !== mq) begin errors++; $display("FAIL rand_q Q=%h expected %h", y, mq); end
  endtask

  task automatic test_reset_mid();
    setin(ins(3'd3, 3'd3, 3'd7), 0, 0, 8'hA5, 1'b0); tick(1);
    setin(ins(3'd1, 3'd3, 3'd4), 0, 0, 8'h00, 1'b0); #1;
    checks++;
    if (y !== 8'hA5) begin errors++; $display("FAIL pre_reset R0=%h expected a5", y); end
    rst = 1'b1; #1;
    checks++;
    if ({y, busy, done} !== 10'h000) begin
      errors++; $display("FAIL reset_async y=%h busy=%b done=%b expected 00 0 0", y, busy, done);
    end
    @(negedge cp) rst = 1'b0;
    clear_model();
    #1;
    for (int k = 0; k < 16; k++) begin
      setin(ins(3'd1, 3'd3, 3'd4), 4'(k), 0, 8'h00, 1'b0); #1;
      checks++;
      if (y !== 8'h00) begin errors++; $display("FAIL reset_reg R%0d=%h expected 00", k, y); end
    end
    setin(ins(3'd1, 3'd3, 3'd2), 0, 0, 8'h00, 1'b0); #1;
    checks++;
    if (y !== 8'h00) begin errors++; $display("FAIL reset_q Q=%h expected 00", y); end
    @(posedge cp); #1;
  endtask

  task automatic test_multiply();
    setin(ins(3'd3, 3'd3, 3'd7), 0, 6, 8'd200, 1'b0); tick(1);
    setin(ins(3'd3, 3'd3, 3'd7), 0, 7, 8'd250, 1'b0); tick(1);
    setin(ins(3'd3, 3'd0, 3'd1), 6, 7, 8'h00, 1'b0);
    mul_start = 1'b1;
    tick(0);
    mul_start = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      checks++;
      if ({busy, done} !== {c < 9, c == 8}) begin
        errors++; $display("FAIL mul_hs cycle=%0d busy=%b done=%b expected %b %b", c, busy, done, c < 9, c == 8);
      end
      if (c == 8) begin
        checks++;
        if ({y, cout, f_msb} !== {8'hC3, 2'b11}) begin
          errors++; $display("FAIL mul_busy_out y=%h cout=%b fmsb=%b expected c3 1 1", y, cout, f_msb);
        end
      end
      if (c < 9) tick(0);
    end
    setin(ins(3'd1, 3'd3, 3'd4), 7, 0, 8'h00, 1'b0); #1;
    checks++;
    if (y !== 8'hC3) begin errors++; $display("FAIL mul_hi R7=%h expected c3", y); end
    setin(ins(3'd1, 3'd3, 3'd2), 0, 0, 8'h00, 1'b0); #1;
    checks++;
    if (y !== 8'h50) begin errors++; $display("FAIL mul_lo Q=%h expected 50", y); end
    mr[7] = 8'hC3; mq = 8'h50;
    tick(1);
  endtask

  task automatic test_mul_abort();
    bit seen_done;
    setin(ins(3'd3, 3'd3, 3'd7), 0, 6, 8'd200, 1'b0); tick(1);
    setin(ins(3'd3, 3'd3, 3'd7), 0, 7, 8'd250, 1'b0); tick(1);
    setin(ins(3'd3, 3'd0, 3'd1), 6, 7, 8'h00, 1'b0);
    mul_start = 1'b1;
    tick(0);
    mul_start = 1'b0;
    repeat (3) tick(0);
    #2 rst = 1'b1; #1;
    checks++;
    if ({busy, done, y} !== 10'h000) begin
      errors++; $display("FAIL abort_async busy=%b done=%b y=%h expected 0 0 00", busy, done, y);
    end
    @(posedge cp); #1;
    @(negedge cp) rst = 1'b0;
    clear_model();
    seen_done = 1'b0;
    setin(ins(3'd1, 3'd3, 3'd4), 7, 0, 8'h00, 1'b0);
    repeat (12) begin
      tick(0);
      seen_done |= done;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_done seen=%b expected 0", seen_done); end
    checks++;
    if (y !== 8'h00) begin errors++; $display("FAIL abort_r7 R7=%h expected 00", y); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] x, v, h1;
    int         p1, p2;
    x = 8'($urandom_range(255, 1));
    v = 8'($urandom_range(255, 1));
    p1 = int'(x) * int'(v);
    h1 = p1[15:8];
    p2 = int'(x) * int'(h1);
    setin(ins(3'd3, 3'd3, 3'd7), 0, 8, x, 1'b0); tick(1);
    setin(ins(3'd3, 3'd3, 3'd7), 0, 9, v, 1'b0); tick(1);
    setin(ins(3'd1, 3'd3, 3'd4), 8, 9, 8'h00, 1'b0);
    mul_start = 1'b1;
    tick(0);
    for (int c = 1; c <= 10; c++) begin
      tick(0);
      if (c == 9) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap busy=%b expected 0", busy); end
      end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart busy=%b expected 1", busy); end
    mul_start = 1'b0;
    repeat (9) tick(0);
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_end busy=%b done=%b expected 0 0", busy, done); end
    setin(ins(3'd1, 3'd3, 3'd4), 9, 0, 8'h00, 1'b0); #1;
    checks++;
    if (y !== p2[15:8]) begin errors++; $display("FAIL b2b_hi x=%h v=%h R9=%h expected %h", x, v, y, p2[15:8]); end
    setin(ins(3'd1, 3'd3, 3'd2), 0, 0, 8'h00, 1'b0); #1;
    checks++;
    if (y !== p2[7:0]) begin errors++; $display("FAIL b2b_lo x=%h v=%h Q=%h expected %h", x, v, y, p2[7:0]); end
  endtask

  initial begin
    {ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in} = 4'b0000;
    oe_n = 1'b0;
    mul_start = 1'b0;
    clear_model();
    test_reset();
    test_overflow();
    test_shift_down();
    test_carry_zero();
    test_random();
    test_reset_mid();
    test_multiply();
    test_mul_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/am2901_wide.md
Name: am2901_wide

Overview:
- Parametrised successor to the 4-bit Am2901 slice: WIDTH-bit datapath, REGS-deep two-port register file, the same 9-bit microinstruction, Q register and RAM/Q shifters.
- Adds a built-in multi-cycle unsigned multiply sequencer (shift-and-add through Q) with a start/busy/done handshake.
- Sits where the controller+datapath pair sits today, as a single synthesizable RTL block.

Parameters:
- WIDTH, 8, datapath width in bits (>=4).
- REGS, 16, register file depth (power of 2); AW = log2(REGS).

Ports:
- cp  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- i  in  9  microinstruction: i[2:0] source, i[5:3] function, i[8:6] destination
- a, b  in  AW  register addresses (A read; B read/write)
- d  in  WIDTH  direct data input
- cin  in  1  ALU carry-in
- oe_n  in  1  y output enable, active low
- y  out  WIDTH  data output (all-zero when oe_n=1)
- cout, ovr, z, f_msb  out  1  carry-out, signed overflow, F==0, F[WIDTH-1]
- g_lo, p_lo  out  1  active-low group generate/propagate
- ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in  in  1  shifter inputs
- ram_lsb_out, ram_msb_out, q_lsb_out, q_msb_out  out  1  shifter outputs
- ram_lsb_oe, ram_msb_oe, q_lsb_oe, q_msb_oe  out  1  shifter output enables
- mul_start  in  1  start multiply R[a]*R[b]
- busy  out  1  multiply in progress
- done  out  1  multiply writeback cycle

Behaviour:
- Reset (async): all registers, Q, accumulator, counter cleared; state=IDLE; busy=done=0. All other outputs are combinational from cleared state.
- Source i[2:0] (R,S): 0 AQ, 1 AB, 2 0Q, 3 0B, 4 0A, 5 DA, 6 DQ, 7 D0.
- Function i[5:3]: 0 R+S+cin, 1 ~R+S+cin, 2 R+~S+cin, 3 R|S, 4 R&S, 5 ~R&S, 6 R^S, 7 ~(R^S).
- Arithmetic at WIDTH+1 bits: cout = bit WIDTH; ovr = carry into MSB xor cout.
- Lookahead (arith ops) uses post-inversion operands: p_k=r_k|s_k, g_k=r_k&s_k; p_lo=~&p; g_lo = ~(group generate).
- Logic ops force cout=ovr=0; g_lo, p_lo still computed.
- Destination i[8:6]:
  - 0 QREG: Q<=F, y=F.
  - 1 NOP: y=F.
  - 2 RAMA: R[b]<=F, y=R[a].
  - 3 RAMF: R[b]<=F, y=F.
  - 4 RAMQD: R[b]<={ram_msb_in,F[W-1:1]}, Q<={q_msb_in,Q[W-1:1]}.
  - 5 RAMD: as 4, Q unchanged.
  - 6 RAMQU: R[b]<={F[W-2:0],ram_lsb_in}, Q<={Q[W-2:0],q_lsb_in}.
  - 7 RAMU: as 6, Q unchanged.
  - y=F for dests 4-7.
- Shifter outputs: for down shifts ram_lsb_out=F[0] and q_lsb_out=Q[0], with the lsb oe's =1. For up shifts ram_msb_out=F[W-1] and q_msb_out=Q[W-1], with the msb oe's =1. All other oe's =0; outputs are 0 when not enabled.
- Register file: reads are combinational; writes occur on the rising cp edge. A write to R[b] with a==b is visible to A only next cycle.
- Multiply FSM (IDLE, MUL, WB):
  - IDLE: mul_start=1 at edge k latches M=R[b] and bl=b, sets Q<=R[a], acc<=0, cnt<=0, state<=MUL. The instruction at that edge still executes, except its Q and R writes are suppressed.
  - MUL: each edge, sum={1'b0,acc}+(Q[0]?M:0); {acc,Q}<={sum,Q}>>1; cnt++. After WIDTH steps (edge k+WIDTH) state<=WB.
  - WB: done=1 combinationally. Edge k+WIDTH+1 writes R[bl]<=acc; state<=IDLE.
  - Result: high half in R[bl], low half in Q.
  - busy=1 in MUL and WB. While busy, i causes no register/Q writes, y=acc, and the flags reflect the current i's combinational ALU.
  - mul_start while busy is ignored. Reset mid-multiply aborts; no writeback occurs.
  - Back-to-back: mul_start sampled in the first IDLE cycle after WB.

Decomposition:
- Package am2901_pkg: source/function/destination encodings as enums, FSM state typedef, opcode field-slice constants.
- One sub-module am2901_alu: combinational, parametrised by WIDTH. Produces F, cout, ovr, g_lo, p_lo from R, S, cin, function.
- Register file, Q, shifters and multiply FSM live in the top.

Test Plan (WIDTH=8, REGS=16, oe_n=0):
1. Reset mid-operation: assert rst asynchronously -> y=0, busy=done=0 immediately; all R and Q read 0 afterwards.
2. Signed overflow: load R1=0x7F, R2=0x01 via DZ/RAMF; then i={RAMF,ADD,AB}, a=1, b=2, cin=0 -> y=0x80, ovr=1, cout=0, f_msb=1, z=0; R2=0x80 after edge.
3. Double shift down: R3=0x81, Q=0x01, ram_msb_in=1, q_msb_in=0; i={RAMQD,OR,ZB}, b=3 -> ram_lsb_out=1, q_lsb_out=1, both lsb oe=1; after edge R3=0xC0, Q=0x00.
4. Carry and zero: R4=0xFF, R5=0x01; i={NOP,ADD,AB} -> y=0x00, z=1, cout=1, p_lo=0, g_lo=0.
5. Multiply: R6=200, R7=250, a=6, b=7, mul_start pulse at edge k -> busy high k+1..k+9; done high only in cycle after edge k+8; after edge k+9 R7=0xC3, Q=0x50; busy=0.
6. Multiply aborted by rst at edge k+4 -> busy=0 at once; done never asserts; R7 reads 0.
